// File: rtl/csa_accumulator_pkg.sv
// Shared types and helpers for the carry-save streaming accumulator.
package csa_pkg;

    typedef enum logic [1:0] {ACC, FIN, OUT} state_t;

    // Default configuration; the accumulator recomputes these from its own parameters.
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int CLA_BLOCKS = DEF_ACC_W / 4;
    localparam int OVF_LIMIT  = 2 ** (DEF_ACC_W - DEF_WIDTH);

    // Widest accumulator the extension helper supports.
    localparam int MAX_W = 64;

    // Sign- or zero-extend the low `width` bits of v to MAX_W bits.
    function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v,
                                                input int width, input bit sgn);
        logic [MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < MAX_W; i++)
            if (i >= width) r[i] = sgn & v[width-1];
        return r;
    endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Input beat and result handshakes of the accumulator.
interface csa_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int ACC_W = 24,
    parameter int CNT_W = ACC_W - WIDTH + 1
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       in_mask;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_sum;
    logic [CNT_W-1:0]       out_count;
    logic                   out_ovf;

    modport master (output in_valid, in_data, in_mask, in_last, out_ready,
                    input  in_ready, out_valid, out_sum, out_count, out_ovf);
    modport slave  (input  in_valid, in_data, in_mask, in_last, out_ready,
                    output in_ready, out_valid, out_sum, out_count, out_ovf);
endinterface

// File: rtl/csa_accumulator_row.sv
// One 3:2 compressor row: bitwise full adders, carry returned unshifted.
module csa_row #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: redundant S/C across beats, CLA resolve at packet end.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = 2,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SIGNED = 0,
    parameter int CNT_W  = ACC_W - WIDTH + 1
) (
    input logic              clk,
    input logic              rst_n,
    csa_accumulator_if.slave bus
);
    localparam int CLA_N = ACC_W / 4;
    localparam logic [CNT_W:0] OVF_LIM = (CNT_W+1)'(1) << (ACC_W - WIDTH);

    state_t           state;
    logic [ACC_W-1:0] s_q, c_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;

    logic [LANES-1:0][ACC_W-1:0] lane_ext;
    logic [LANES-1:0][ACC_W-1:0] cy_raw;
    logic [LANES:0][ACC_W-1:0]   s_ch, c_ch;

    assign s_ch[0] = s_q;
    assign c_ch[0] = c_q;

    // Per-lane extension followed by one compressor row; carry is shifted into the next row.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [MAX_W-1:0] raw;
        assign raw         = MAX_W'(bus.in_data[k*WIDTH +: WIDTH]);
        assign lane_ext[k] = bus.in_mask[k] ? ACC_W'(extend(raw, WIDTH, SIGNED != 0)) : '0;

        csa_row #(.W(ACC_W)) u_row (
            .a     (s_ch[k]),
            .b     (c_ch[k]),
            .c     (lane_ext[k]),
            .sum   (s_ch[k+1]),
            .carry (cy_raw[k])
        );
        assign c_ch[k+1] = cy_raw[k] << 1;
    end

    // Popcount of enabled lanes and saturating operand counter update.
    logic [2:0]       pop;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) pop = pop + 3'(bus.in_mask[i]);
    end
    assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pop);
    assign cnt_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    // Resolve S + C through chained 4-bit lookahead blocks; the top carry-out is dropped.
    logic [CLA_N-1:0] cla_c;
    logic [ACC_W-1:0] cla_sum;
    assign cla_c[0] = 1'b0;
    for (genvar b = 0; b < CLA_N; b++) begin : g_cla
        logic [3:0] g, p, cc;
        assign g     = s_q[4*b +: 4] & c_q[4*b +: 4];
        assign p     = s_q[4*b +: 4] ^ c_q[4*b +: 4];
        assign cc[0] = cla_c[b];
        assign cc[1] = g[0] | (p[0] & cc[0]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cc[0]);
        assign cla_sum[4*b +: 4] = p ^ cc;
        if (b < CLA_N - 1) begin : g_co
            assign cla_c[b+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                                (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cc[0]);
        end
    end

    // Packet FSM: accumulate, resolve for one cycle, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACC;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state)
                ACC: if (bus.in_valid) begin
                    s_q   <= s_ch[LANES];
                    c_q   <= c_ch[LANES];
                    cnt_q <= cnt_nxt;
                    if (bus.in_last) state <= FIN;
                end
                FIN: begin
                    out_sum_q   <= cla_sum;
                    out_count_q <= cnt_q;
                    out_ovf_q   <= {1'b0, cnt_q} > OVF_LIM;
                    state       <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    s_q   <= '0;
                    c_q   <= '0;
                    cnt_q <= '0;
                    state <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == OUT);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: unsigned and signed instances with hand-computed results.
module tb_csa_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csa_accumulator_if #(.WIDTH(16), .LANES(2), .ACC_W(24), .CNT_W(9)) bus ();
    csa_accumulator_if #(.WIDTH(16), .LANES(2), .ACC_W(24), .CNT_W(9)) bus_s ();

    csa_accumulator #(.WIDTH(16), .LANES(2), .ACC_W(24), .SIGNED(0), .CNT_W(9)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    csa_accumulator #(.WIDTH(16), .LANES(2), .ACC_W(24), .SIGNED(1), .CNT_W(9)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One beat on the unsigned instance; called #1 after a rising edge.
    task automatic beat(input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] m, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = {d1, d0};
        bus.in_mask  = m;
        bus.in_last  = l;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("consume_valid_low", 32'(bus.out_valid), 32'd0);
        chk("consume_ready_high", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;   bus.in_data = '0;   bus.in_mask = '0;   bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_mask = '0; bus_s.in_last = 1'b0;
        bus_s.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 9 x 0xFFFF; the masked lane of the last beat carries junk that must be ignored.
        repeat (4) beat(16'hFFFF, 16'hFFFF, 2'b11, 1'b0);
        beat(16'hFFFF, 16'h1234, 2'b01, 1'b1);
        chk("uns_fin_valid", 32'(bus.out_valid), 32'd0);
        chk("uns_fin_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("uns_valid", 32'(bus.out_valid), 32'd1);
        chk("uns_sum", 32'(bus.out_sum), 32'h08FFF7);
        chk("uns_count", 32'(bus.out_count), 32'd9);
        chk("uns_ovf", 32'(bus.out_ovf), 32'd0);
        consume();

        // Signed instance: 0x8000 + 0x0001 sign-extended to 24 bits.
        bus_s.in_valid = 1'b1;
        bus_s.in_data  = {16'h0001, 16'h8000};
        bus_s.in_mask  = 2'b11;
        bus_s.in_last  = 1'b1;
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("sgn_valid", 32'(bus_s.out_valid), 32'd1);
        chk("sgn_sum", 32'(bus_s.out_sum), 32'hFF8001);
        chk("sgn_count", 32'(bus_s.out_count), 32'd2);

        // Backpressure: result 3 held while the next packet waits upstream.
        beat(16'd1, 16'd2, 2'b11, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = {16'd4, 16'd3};
        bus.in_mask  = 2'b11;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_sum", 32'(bus.out_sum), 32'd3);
            chk("bp_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_sum", 32'(bus.out_sum), 32'd7);
        chk("bp_next_count", 32'(bus.out_count), 32'd2);
        consume();

        // Empty packet with nonzero data on masked lanes.
        beat(16'hAAAA, 16'h5555, 2'b00, 1'b1);
        wait_out("empty");
        chk("empty_sum", 32'(bus.out_sum), 32'd0);
        chk("empty_count", 32'(bus.out_count), 32'd0);
        chk("empty_ovf", 32'(bus.out_ovf), 32'd0);
        consume();

        // Exactly 256 operands: at the limit, not over it.
        repeat (127) beat(16'hFFFF, 16'hFFFF, 2'b11, 1'b0);
        beat(16'hFFFF, 16'hFFFF, 2'b11, 1'b1);
        wait_out("lim");
        chk("lim_sum", 32'(bus.out_sum), 32'hFFFF00);
        chk("lim_count", 32'(bus.out_count), 32'd256);
        chk("lim_ovf", 32'(bus.out_ovf), 32'd0);
        consume();

        // 257 operands: sum wraps and overflow is flagged.
        repeat (128) beat(16'hFFFF, 16'hFFFF, 2'b11, 1'b0);
        beat(16'hFFFF, 16'h0000, 2'b01, 1'b1);
        wait_out("ovf");
        chk("ovf_sum", 32'(bus.out_sum), 32'h00FEFF);
        chk("ovf_count", 32'(bus.out_count), 32'd257);
        chk("ovf_ovf", 32'(bus.out_ovf), 32'd1);
        consume();

        // Reset mid-packet discards the partial sum and the previous result.
        beat(16'd1, 16'd1, 2'b11, 1'b0);
        beat(16'd1, 16'd1, 2'b11, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus.out_sum), 32'd0);
        chk("mid_rst_count", 32'(bus.out_count), 32'd0);
        chk("mid_rst_ovf", 32'(bus.out_ovf), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(16'd3, 16'd4, 2'b11, 1'b1);
        wait_out("post_rst");
        chk("post_rst_sum", 32'(bus.out_sum), 32'd7);
        chk("post_rst_count", 32'(bus.out_count), 32'd2);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Streaming multi-operand accumulator built on carry-save compression. It is the sequential, parametrised successor to the fixed 9×16-bit carry-save adder tree. It accepts packets of `WIDTH`-bit operands, `LANES` per beat, under a valid/ready handshake. Sum and carry are kept in redundant form across beats, so no carry propagates inside the accumulate loop. Only the packet end is resolved, by a chained 4-bit carry-lookahead adder, and the result is presented on an output handshake.

## Interface
- `WIDTH`, 16: operand width in bits.
- `LANES`, 2: operands per beat. Legal range 1..4.
- `ACC_W`, 24: result width. Must be at least `WIDTH+1` and a multiple of 4.
- `SIGNED`, 0: 1 means operands are two's complement and are sign-extended to `ACC_W`; 0 means zero-extended.
- `CNT_W`, `ACC_W-WIDTH+1`: operand counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_data` in `LANES*WIDTH`: lane k occupies bits `[k*WIDTH +: WIDTH]`.
- `in_mask` in `LANES`: lane enable. A masked lane contributes 0 and is not counted.
- `in_last` in 1: this beat closes the packet.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_sum` out `ACC_W`: packet sum modulo 2^`ACC_W`.
- `out_count` out `CNT_W`: number of unmasked operands, saturating at all-ones.
- `out_ovf` out 1: packet held more than 2^(`ACC_W-WIDTH`) operands, so the sum may have wrapped.

## Operation
- **State ACC**
  - `in_ready=1`.
  - On an accepted beat, extend each unmasked lane to `ACC_W`.
  - Compress {S, C, lane0..laneN-1} to a new {S, C} through a chain of `LANES` 3:2 compressor rows.
  - After each row, C is shifted left by 1 with the MSB dropped (modulo arithmetic).
  - Count increases by popcount(`in_mask`).
  - If `in_last`, go to FIN.
- **State FIN**
  - `in_ready=0`; lasts one cycle.
  - Register `out_sum = S + C` from `ACC_W/4` chained 4-bit CLAs with carry-in 0; final carry-out discarded.
  - Register `out_count`, and set `out_ovf = (count > 2^(ACC_W-WIDTH))`.
  - Go to OUT.
- **State OUT**
  - `out_valid=1`, `in_ready=0`. `out_sum`, `out_count` and `out_ovf` are held stable.
  - On `out_ready`: clear S, C and count, then go to ACC.
  - Any `in_valid` during FIN/OUT is ignored; the upstream must hold it.
- **Edge cases**
  - Empty packet (`in_last` with `in_mask=0`, or the first beat masked) is legal: sum 0, count 0.
  - A beat with `in_valid=0` changes nothing.
  - `in_mask`, `in_data` and `in_last` are don't-care when `in_valid=0`.

## Timing
- **Reset values:** state ACC; S, C and count 0; `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_count=0`, `out_ovf=0`.
- **Reset mid-packet or mid-OUT:** the partial packet and any pending result are discarded with no output.
- **Throughput:** one beat per clock in ACC.
- **Latency:** last beat accepted at edge t, then FIN during cycle t→t+1, then `out_valid` is high from edge t+1.
- **Dead time:** minimum 2 cycles per packet where `in_ready=0` (FIN plus at least one OUT cycle).
- `out_valid` falls on the edge where `out_ready` is sampled high. `in_ready` rises in the same cycle, combinationally from state.
- **Register boundary:** the full CSA chain for one beat is a single register stage. The CLA chain is the only carry-propagate path.

## Structure
- **Package `csa_pkg`:**
  - state enum {ACC, FIN, OUT}.
  - localparams `CLA_BLOCKS = ACC_W/4` and `OVF_LIMIT = 2**(ACC_W-WIDTH)`.
  - a sign/zero extension function.
- **Sub-module `csa_row`:** parametrised-width 3:2 compressor, bitwise full adders, outputs sum and unshifted carry. It is instantiated `LANES` times.
- The 4-bit CLA is generated inline.

## Test plan
All scenarios use `WIDTH=16`, `LANES=2`, `ACC_W=24` unless stated.

- **Unsigned sum:** 9 × `0xFFFF`, as 4 full beats plus 1 beat with mask `01` and `in_last` → `out_sum=0x08FFF7`, `out_count=9`, `out_ovf=0`, `out_valid` exactly 1 cycle after the last-beat edge.
- **Signed:** `SIGNED=1`, one beat {`0x8000`, `0x0001`} with `in_last` → `out_sum=0xFF8001`, `out_count=2`.
- **Backpressure:** `out_ready` held low for 3 cycles with `in_valid` high → `out_valid` and `out_sum` stable and `in_ready=0` throughout. After `out_ready` is raised, the next packet {3, 4} yields 7.
- **Empty packet:** `in_last` with `in_mask=00` → `out_sum=0`, `out_count=0`, `out_ovf=0`.
- **Overflow:** 257 × `0xFFFF` (128 full beats plus a last beat with mask `01`) → `out_sum=0x00FEFF`, `out_count=257`, `out_ovf=1`.
- **Reset mid-packet:** `rst_n` pulsed low after 2 beats → all outputs 0 immediately. A following packet {3, 4} with `in_last` → `out_sum=7`, `out_count=2`.
